// File: rtl/uart_alu_interface_if.sv
// Handshake and data bus between the UART/ALU control stage and its
// environment: receiver byte strobe, ALU operands/result, and transmitter
// start/done.
interface uart_alu_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_rx_data;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;
    logic               o_timeout;

    // Control stage side
    modport slave (
        input  i_rx_done,
        input  i_rx_data,
        input  i_alu_result,
        input  i_tx_done,
        output o_data_a,
        output o_data_b,
        output o_op,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_timeout
    );

    // Receiver / ALU / transmitter side
    modport master (
        output i_rx_done,
        output i_rx_data,
        output i_alu_result,
        output i_tx_done,
        input  o_data_a,
        input  o_data_b,
        input  o_op,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_timeout
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Control stage between UART receiver/ALU and UART transmitter.
// Collects operand A, operand B and opcode bytes, lets the ALU settle for
// one cycle, latches the result and issues a one-cycle transmit start, then
// waits for transmit-done before accepting the next frame.
// Optional inter-byte timeout: define INTERFACE_TIMEOUT_EN.
module uart_alu_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic                 i_clk,
    input logic                 i_rst,
    uart_alu_interface_if.slave bus
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EVAL    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] tx_data_q;

    logic               cap_a;
    logic               cap_b;
    logic               cap_op;
    logic               cap_res;
    logic               timeout_hit;
    logic               timeout_q;

`ifdef INTERFACE_TIMEOUT_EN
    localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [NB_CNT-1:0]  cnt_q;
    logic               in_wait_byte;

    assign in_wait_byte = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign timeout_hit  = in_wait_byte && !bus.i_rx_done &&
                          (cnt_q == NB_CNT'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter; runs only while waiting for B or the opcode
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (in_wait_byte && !bus.i_rx_done && !timeout_hit) begin
                cnt_q <= cnt_q + NB_CNT'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_q   = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and capture-enable decode
    always_comb begin
        state_d = state_q;
        cap_a   = 1'b0;
        cap_b   = 1'b0;
        cap_op  = 1'b0;
        cap_res = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (bus.i_rx_done) begin
                    cap_a   = 1'b1;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.i_rx_done) begin
                    cap_b   = 1'b1;
                    state_d = WAIT_OP;
                end else if (timeout_hit) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    cap_op  = 1'b1;
                    state_d = EVAL;
                end else if (timeout_hit) begin
                    state_d = WAIT_A;
                end
            end
            EVAL: begin
                cap_res = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // Operand, opcode and result registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            data_a_q  <= '0;
            data_b_q  <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
        end else begin
            if (cap_a) begin
                data_a_q <= bus.i_rx_data;
            end
            if (cap_b) begin
                data_b_q <= bus.i_rx_data;
            end
            if (cap_op) begin
                op_q <= bus.i_rx_data[NB_OP-1:0];
            end
            if (cap_res) begin
                tx_data_q <= bus.i_alu_result;
            end
        end
    end

    assign bus.o_data_a   = data_a_q;
    assign bus.o_data_b   = data_b_q;
    assign bus.o_op       = op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = (state_q == SEND);
    assign bus.o_busy     = (state_q == EVAL) || (state_q == SEND) ||
                            (state_q == WAIT_TX);
    assign bus.o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: frames are issued with random
// gaps, the expected transmit word is queued, and a negedge monitor checks
// each transmit start pulse against the queue.
module tb_uart_alu_interface;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        int         cyc;
    } exp_t;

    logic i_clk;
    logic i_rst;
    int   pcyc    = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    int   n_pulse = 0;
    int   n_tmo   = 0;
    int   n_exp   = 0;
    logic prev_start = 1'b0;
    exp_t sb[$];

    uart_alu_interface_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    uart_alu_interface #(
        .NB_DATA(NB_DATA),
        .NB_OP(NB_OP),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus)
    );

    // Behavioural ALU: opcode meanings as used on the link
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.i_alu_result = alu_f(bus.o_data_a, bus.o_data_b, bus.o_op);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_check++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    // Monitor: every start pulse must match the oldest expected frame
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (bus.o_tx_start) begin
                n_pulse++;
                chk("start_width", int'(prev_start), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", int'(bus.o_tx_data), int'(e.res));
                    chk("data_a", int'(bus.o_data_a), int'(e.a));
                    chk("data_b", int'(bus.o_data_b), int'(e.b));
                    chk("op", int'(bus.o_op), int'(e.op));
                    chk("latency", pcyc, e.cyc);
                    chk("busy_send", int'(bus.o_busy), 1);
                end
            end
            if (bus.o_timeout) n_tmo++;
            prev_start = bus.o_tx_start;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, output int p);
        repeat (gap) @(negedge i_clk);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = b;
        p = pcyc;
        @(negedge i_clk);
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'($urandom);
    endtask

    // Sends a frame (optionally without A, when A is already held) and
    // queues its expected result
    task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input bit skip_a);
        int   p;
        exp_t e;
        if (!skip_a) send_byte(a, $urandom_range(0, 4), p);
        send_byte(b, $urandom_range(0, 4), p);
        send_byte(opb, $urandom_range(0, 4), p);
        e.a   = a;
        e.b   = b;
        e.op  = opb[5:0];
        e.res = alu_f(a, b, opb[5:0]);
        e.cyc = p + 2;
        sb.push_back(e);
        n_exp++;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!bus.o_tx_start && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!bus.o_tx_start) chk("start_timeout", 0, 1);
    endtask

    task automatic pulse_tx_done(input bit with_rx, input logic [7:0] rxb);
        bus.i_tx_done = 1'b1;
        bus.i_rx_done = with_rx;
        bus.i_rx_data = rxb;
        @(negedge i_clk);
        bus.i_tx_done = 1'b0;
        bus.i_rx_done = 1'b0;
    endtask

    task automatic finish_tx();
        wait_start();
        repeat ($urandom_range(1, 5)) @(negedge i_clk);
        chk("busy_wait_tx", int'(bus.o_busy), 1);
        pulse_tx_done(1'b0, 8'h00);
        chk("busy_idle", int'(bus.o_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tx_done = 1'b0;
        i_rst = 1'b0;
        #2;
        chk("rst_data_a", int'(bus.o_data_a), 0);
        chk("rst_data_b", int'(bus.o_data_b), 0);
        chk("rst_op", int'(bus.o_op), 0);
        chk("rst_tx_data", int'(bus.o_tx_data), 0);
        chk("rst_tx_start", int'(bus.o_tx_start), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_timeout", int'(bus.o_timeout), 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);

        // Basic frame and back-to-back frames
        do_frame(8'h05, 8'h03, 8'h20, 1'b0);
        finish_tx();
        do_frame(8'hFF, 8'h01, 8'h20, 1'b0);
        finish_tx();
        do_frame(8'h0C, 8'h0A, 8'h24, 1'b0);
        finish_tx();

        // Byte arriving during WAIT_TX is dropped
        do_frame(8'h44, 8'h10, 8'h22, 1'b0);
        wait_start();
        @(negedge i_clk);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'h77;
        @(negedge i_clk);
        bus.i_rx_done = 1'b0;
        chk("drop_data_a", int'(bus.o_data_a), 8'h44);
        pulse_tx_done(1'b0, 8'h00);
        do_frame(8'h01, 8'h02, 8'h20, 1'b0);
        finish_tx();

        // rx_done and tx_done together in WAIT_TX
        do_frame(8'h11, 8'h22, 8'h25, 1'b0);
        wait_start();
        @(negedge i_clk);
        pulse_tx_done(1'b1, 8'h09);
        chk("simul_data_a", int'(bus.o_data_a), 8'h11);
        chk("simul_busy", int'(bus.o_busy), 0);
        do_frame(8'h30, 8'h0F, 8'h26, 1'b0);
        finish_tx();

        // Reset mid-frame
        begin
            int p;
            send_byte(8'h05, 0, p);
            send_byte(8'h03, 0, p);
        end
        i_rst = 1'b0;
        #1;
        chk("mid_rst_data_a", int'(bus.o_data_a), 0);
        chk("mid_rst_data_b", int'(bus.o_data_b), 0);
        chk("mid_rst_busy", int'(bus.o_busy), 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        do_frame(8'h02, 8'h02, 8'h20, 1'b0);
        finish_tx();

        // Random frames
        for (int i = 0; i < 12; i++) begin
            logic [7:0] ra, rb, ro;
            logic [7:0] ops [8];
            ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h3F};
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = {2'($urandom), 6'h00} | ops[$urandom_range(0, 7)];
            do_frame(ra, rb, ro, 1'b0);
            finish_tx();
        end

        // Idle after operand A
        begin
            int p;
            send_byte(8'h05, 0, p);
        end
        repeat (24) @(negedge i_clk);
        chk("idle_busy", int'(bus.o_busy), 0);
`ifdef INTERFACE_TIMEOUT_EN
        chk("timeout_pulses", n_tmo, 1);
        do_frame(8'h06, 8'h03, 8'h20, 1'b0);
`else
        chk("timeout_pulses", n_tmo, 0);
        do_frame(8'h05, 8'h03, 8'h20, 1'b1);
`endif
        finish_tx();

        repeat (5) @(negedge i_clk);
        chk("pulse_count", n_pulse, n_exp);
        chk("queue_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
